// File: rtl/relu_maxpool.sv
// Max-pool stage behind the ReLU unit: running max over non-overlapping windows of
// WINDOW samples, one-entry valid/ready output register, sticky drop tracking.
module relu_maxpool #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        win_cnt,
  output logic              drop_err,
  output logic [7:0]        drop_cnt
);

  localparam logic [7:0] LAST = 8'(WINDOW - 1);

  logic [DATA_W-1:0] max_reg;
  logic [DATA_W-1:0] result;
  logic              last;
  logic              done;

  // First sample of a window loads directly; with WINDOW==1 win_cnt stays 0,
  // so result is always in_data.
  always_comb begin
    last = (win_cnt == LAST);
    if (win_cnt == 8'd0)       result = in_data;
    else if (in_data > max_reg) result = in_data;
    else                        result = max_reg;
    done = in_valid && last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      max_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      drop_err  <= 1'b0;
      drop_cnt  <= '0;
    end else if (clr) begin
      win_cnt   <= '0;
      max_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      drop_err  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (in_valid) begin
        max_reg <= result;
        win_cnt <= last ? 8'd0 : win_cnt + 8'd1;
      end
      // Input cannot stall, so a completed window facing a full register is lost.
      if (done && (!out_valid || out_ready)) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (done) begin
        drop_err <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: WINDOW=4 instance plus a WINDOW=1 instance on
// the same inputs.
module tb_relu_maxpool;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       ov4, ov1, de4, de1;
  logic [7:0] od4, od1, wc4, wc1, dc4, dc1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  relu_maxpool #(.DATA_W(8), .WINDOW(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .win_cnt(wc4),
    .drop_err(de4), .drop_cnt(dc4)
  );

  relu_maxpool #(.DATA_W(8), .WINDOW(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .win_cnt(wc1),
    .drop_err(de1), .drop_cnt(dc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then advance to just after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w4(input string tag, input logic v, input logic [7:0] d,
                        input logic [7:0] wc, input logic e, input logic [7:0] dc);
    chk({tag, ".out_valid"}, 32'(ov4), 32'(v));
    chk({tag, ".out_data"},  32'(od4), 32'(d));
    chk({tag, ".win_cnt"},   32'(wc4), 32'(wc));
    chk({tag, ".drop_err"},  32'(de4), 32'(e));
    chk({tag, ".drop_cnt"},  32'(dc4), 32'(dc));
  endtask

  initial begin
    logic [7:0] s3 [4];
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1. Reset with random inputs for 100ns
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      clr       = 1'($urandom);
      @(posedge clk);
      #1;
      if (i == 4) chk_w4("rst_mid", 0, 8'h00, 8'd0, 0, 8'd0);
    end
    chk_w4("rst_end", 0, 8'h00, 8'd0, 0, 8'd0);
    chk("rst_w1.out_valid", 32'(ov1), 0);
    chk("rst_w1.drop_cnt", 32'(dc1), 0);
    clr = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'($urandom);
      step(1'b0, 8'($urandom));
    end
    chk_w4("post_rst", 0, 8'h00, 8'd0, 0, 8'd0);

    // 2. Basic pool
    out_ready = 1'b1;
    step(1'b1, 8'h2E); chk("basic.wc1", 32'(wc4), 1);
    step(1'b1, 8'h00); chk("basic.wc2", 32'(wc4), 2);
    step(1'b1, 8'h7F); chk("basic.wc3", 32'(wc4), 3);
    chk("basic.not_yet", 32'(ov4), 0);
    step(1'b1, 8'h10);
    chk_w4("basic", 1, 8'h7F, 8'd0, 0, 8'd0);
    step(1'b0, 8'hFF);
    chk("basic.consumed", 32'(ov4), 0);
    chk("basic.held", 32'(od4), 32'h7F);

    // 3. Sparse input, one sample every 6 cycles
    s3[0] = 8'h05; s3[1] = 8'h09; s3[2] = 8'h09; s3[3] = 8'h03;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, s3[k]);
      chk($sformatf("sparse.wc%0d", k), 32'(wc4), 32'((k + 1) % 4));
      if (k == 3) begin
        chk("sparse.valid", 32'(ov4), 1);
        chk("sparse.data", 32'(od4), 32'h09);
      end
      for (int j = 0; j < 5; j++) step(1'b0, 8'($urandom));
    end
    chk("sparse.consumed", 32'(ov4), 0);

    // 4. Stall across two windows -> second result dropped
    out_ready = 1'b0;
    step(1'b1, 8'h10); step(1'b1, 8'h40); step(1'b1, 8'h20); step(1'b1, 8'h30);
    chk_w4("stall.w1", 1, 8'h40, 8'd0, 0, 8'd0);
    step(1'b1, 8'h55); step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03);
    chk_w4("stall.w2", 1, 8'h40, 8'd0, 1, 8'd1);
    out_ready = 1'b1;
    step(1'b0, 8'h00);
    chk_w4("stall.drain", 0, 8'h40, 8'd0, 1, 8'd1);

    // 5. Handoff and reload on the same edge
    out_ready = 1'b0;
    step(1'b1, 8'h11); step(1'b1, 8'h00); step(1'b1, 8'h01); step(1'b1, 8'h02);
    chk("hand.pre_v", 32'(ov4), 1);
    chk("hand.pre_d", 32'(od4), 32'h11);
    step(1'b1, 8'h05); step(1'b1, 8'h22); step(1'b1, 8'h10);
    chk("hand.stable", 32'(od4), 32'h11);
    out_ready = 1'b1;
    step(1'b1, 8'h00);
    chk_w4("hand", 1, 8'h22, 8'd0, 1, 8'd1);
    step(1'b0, 8'h00);
    chk("hand.consumed", 32'(ov4), 0);

    // 6. clr mid-window discards the concurrent sample
    step(1'b1, 8'h33); step(1'b1, 8'h44);
    chk("clr.pre_wc", 32'(wc4), 2);
    clr = 1'b1;
    step(1'b1, 8'hFF);
    clr = 1'b0;
    chk_w4("clr", 0, 8'h00, 8'd0, 0, 8'd0);
    chk("clr.w1_valid", 32'(ov1), 0);
    chk("clr.w1_dcnt", 32'(dc1), 0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 8'(k));
      chk($sformatf("w1.data%0d", k), 32'(od1), 32'(k));
      chk($sformatf("w1.valid%0d", k), 32'(ov1), 1);
      chk($sformatf("w1.wc%0d", k), 32'(wc1), 0);
      if (k == 3) chk("fresh.wc3", 32'(wc4), 3);
    end
    chk_w4("fresh", 1, 8'h04, 8'd0, 0, 8'd0);

    // Drop counter saturation: 260 samples with the consumer stalled
    clr = 1'b1;
    step(1'b0, 8'h00);
    clr = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 260; k++) step(1'b1, 8'(k));
    chk("sat.w1_dcnt", 32'(dc1), 255);
    chk("sat.w1_derr", 32'(de1), 1);
    chk("sat.w1_data", 32'(od1), 0);
    chk("sat.w4_dcnt", 32'(dc4), 64);
    chk("sat.w4_data", 32'(od4), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
